prefetch_queue: RTL
===================

# prefetch_queue

Instruction prefetch buffer between instruction memory and the fetch/decode stage of the pipelined core. Generates sequential word addresses and fetches through a req/ack handshake with wait states. Holds up to DEPTH instruction/PC pairs and presents them to decode through a valid/ready interface. Flushes and restarts from a new PC when execute resolves a taken branch.

## Interface

- DEPTH, 4: entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  memory accepts the request and drives imem_data this cycle.
- imem_data  in  32  instruction word, valid when imem_req && imem_ack.
- redirect  in  1  taken branch/jump from execute; one-cycle pulse.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- out_valid  out  1  head entry available.
- out_inst  out  32  head instruction.
- out_pc  out  32  PC of head instruction.
- out_ready  in  1  decode consumes head this cycle.
- occupancy  out  $clog2(DEPTH+1)  entries currently held.

## Operation

- State:
  - fetch_pc (32);
  - circular storage of DEPTH {pc, inst} entries;
  - rd_ptr and wr_ptr, log2(DEPTH) bits each, wrapping modulo DEPTH;
  - count, 0..DEPTH.
- imem_req = (count < DEPTH) && !redirect. imem_addr = fetch_pc.
- Push when imem_req && imem_ack:
  - write {fetch_pc, imem_data} at wr_ptr;
  - wr_ptr+1;
  - fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- While imem_req && !imem_ack (wait state): imem_addr holds stable; nothing pushed.
- out_valid = (count != 0). out_inst and out_pc come from the rd_ptr entry. Pop when out_valid && out_ready: rd_ptr+1.
- Push and pop in the same cycle: count unchanged.
- Full (count == DEPTH): imem_req low. A pop in the same cycle does not re-enable the request until the next cycle; there is no full-bypass.
- Empty: no bypass. A pushed word is visible on out_inst no earlier than the next cycle.
- Redirect, which has priority over everything:
  - count, rd_ptr, wr_ptr go to 0;
  - fetch_pc = {redirect_pc[31:2], 2'b00};
  - imem_req forced low that cycle, so any imem_ack in that cycle is ignored and nothing is pushed;
  - a pop attempted that cycle is discarded, and decode must treat the head as squashed.
- Redirect on consecutive cycles: the last one wins.
- occupancy = count.

## Timing

- Reset asserted, asynchronously:
  - fetch_pc = RESET_PC;
  - count = 0, rd_ptr = 0, wr_ptr = 0;
  - out_valid = 0, occupancy = 0;
  - imem_req = 0 while reset is low, via a registered reset-seen flag gating imem_req. Storage contents are don't-care.
- First cycle after reset release: imem_req = 1, imem_addr = RESET_PC.
- Zero-wait-state memory, out_ready held 1:
  - one instruction per cycle steady state;
  - first instruction out_valid 1 cycle after its ack.
- Redirect in cycle N:
  - cycle N+1: imem_req = 1 with imem_addr = redirect_pc, and out_valid = 0;
  - earliest target instruction on the output: cycle N+2.
- Reset asserted mid-transfer: the ack in progress is dropped, and state returns to reset values immediately.

## Test plan

- Reset and stream: release reset, imem_ack = 1 always, out_ready = 1, imem_data = addr^32'hA5A5_0000 -> out_pc 0,4,8,… one per cycle starting 2 cycles after release, each out_inst matching its PC.
- Fill and backpressure: out_ready = 0, ack = 1 -> after 4 pushes occupancy = 4, imem_req = 0, imem_addr = 0x10. Raise out_ready for 1 cycle -> next cycle imem_req = 1 fetching 0x10.
- Wait states: ack asserted every third cycle -> imem_addr stable across waits, no duplicates or drops, PCs strictly +4.
- Redirect: with 3 entries queued, pulse redirect with redirect_pc = 0x0000_0103 and simultaneous ack/pop -> next cycle occupancy = 0, out_valid = 0, imem_addr = 0x100. Then out_pc = 0x100 appears, and no pre-redirect PC ever appears.
- Wrap-around: redirect to 0xFFFF_FFF8, ack = 1 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4. Storage pointers wrap through all DEPTH slots with data intact.
- Async reset mid-stream: drive reset low between clock edges with occupancy = 3 -> out_valid and occupancy 0 before the next edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/prefetch_queue.sv
// prefetch_queue
//
// Instruction prefetch buffer between instruction memory and decode. It
// fetches sequential word addresses through a req/ack handshake that
// tolerates wait states. Fetched {pc, inst} pairs are held in a small
// circular buffer, and decode drains them through a valid/ready port. A
// taken branch from execute (redirect) flushes the buffer and restarts
// fetching from the new PC.
//
// Parameters
//   DEPTH       buffer entries (power of two, >= 2)
//   RESET_PC    first fetch address after reset (word aligned)
//
// Ports
//   clk           in   clock, all state on rising edge
//   reset         in   asynchronous, active-low
//   imem_req      out  fetch request
//   imem_addr     out  word-aligned fetch address
//   imem_ack      in   memory accepts request, imem_data valid this cycle
//   imem_data     in   fetched instruction word
//   redirect      in   taken branch/jump pulse from execute
//   redirect_pc   in   new fetch PC (bits [1:0] ignored)
//   out_valid     out  head entry available
//   out_inst      out  head instruction
//   out_pc        out  PC of head instruction
//   out_ready     in   decode consumes head this cycle
//   occupancy     out  entries currently held

module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_data,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             reset_seen;

  logic [31:0]      mem_pc   [DEPTH];
  logic [31:0]      mem_inst [DEPTH];

  logic             push;
  logic             pop;
  logic [31:0]      redirect_target;

  // Request is held off until one clock edge has been seen out of reset,
  // so imem_req is low for the whole time reset is asserted. Full is judged
  // on the registered count only: a pop this cycle does not free a slot
  // for a fetch until the next cycle.
  assign imem_req  = reset_seen && (count < CNT_FULL) && !redirect;
  assign imem_addr = fetch_pc;

  assign out_valid = (count != '0);
  assign out_pc    = mem_pc[rd_ptr];
  assign out_inst  = mem_inst[rd_ptr];
  assign occupancy = count;

  // imem_req is already low during redirect, so push can never collide
  // with a flush. Pops during redirect are squashed.
  assign push = imem_req && imem_ack;
  assign pop  = out_valid && out_ready && !redirect;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reset_seen <= 1'b0;
    end else begin
      reset_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; entries are only read when count says they hold
  // valid data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fetch_pc;
      mem_inst[wr_ptr] <= imem_data;
    end
  end

endmodule
